mux2_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 data multiplexer between two requesters, A and B. It grants the shared path to one requester at a time, drives the multiplexer select, and presents the selected word on a single output. An optional hold-timeout preempts a requester that keeps the path while the other one waits. The block sits between the two producer blocks and the shared downstream consumer.

---
 rtl/mux2_arbiter_pkg.sv | 13 +
 rtl/mux_2_1.sv | 11 +
 rtl/mux2_arbiter.sv | 122 ++++++++++++
 tb/tb_mux2_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux2_arbiter_pkg.sv
// Shared encodings for the two-requester mux arbiter: FSM states and owner IDs.
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_A = 2'b01,
    ST_GNT_B = 2'b10
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/mux_2_1.sv
// Single-bit 2:1 multiplexer: D follows B when S is high, otherwise A.
module mux_2_1 (
  input  logic A,
  input  logic B,
  input  logic S,
  output logic D
);

  assign D = S ? B : A;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between requesters A and B.
// Optional hold-timeout preemption is built when MUX2_ARBITER_TIMEOUT_EN is defined.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  if (MAX_HOLD < 2) begin : g_max_hold_check
    $error("mux2_arbiter: MAX_HOLD must be 2 or more");
  end

  state_t state_reg, state_next;
  logic   last_owner_reg;
  logic   sel_reg;
  logic   gnt_a_reg, gnt_b_reg;
  logic   grant_entry;
  logic   preempt_a, preempt_b;

`ifdef MUX2_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_reg;

  // Preempt only while the other side is actually waiting.
  assign preempt_a = (hold_reg == HOLD_LAST) && req_b;
  assign preempt_b = (hold_reg == HOLD_LAST) && req_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_reg <= '0;
    end else if (grant_entry) begin
      hold_reg <= '0;
    end else if (state_next != ST_IDLE && hold_reg != HOLD_LAST) begin
      hold_reg <= hold_reg + 1'b1;
    end
  end
`else
  assign preempt_a = 1'b0;
  assign preempt_b = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_next = (last_owner_reg == OWN_A) ? ST_GNT_B : ST_GNT_A;
        end else if (req_a) begin
          state_next = ST_GNT_A;
        end else if (req_b) begin
          state_next = ST_GNT_B;
        end
      end
      ST_GNT_A: begin
        if (!req_a) begin
          state_next = req_b ? ST_GNT_B : ST_IDLE;
        end else if (preempt_a) begin
          state_next = ST_GNT_B;
        end
      end
      ST_GNT_B: begin
        if (!req_b) begin
          state_next = req_a ? ST_GNT_A : ST_IDLE;
        end else if (preempt_b) begin
          state_next = ST_GNT_A;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Entry covers IDLE->grant and the direct A<->B handoff.
  assign grant_entry = (state_next != ST_IDLE) && (state_next != state_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      gnt_a_reg      <= 1'b0;
      gnt_b_reg      <= 1'b0;
      sel_reg        <= OWN_A;
      last_owner_reg <= OWN_B;
    end else begin
      state_reg <= state_next;
      gnt_a_reg <= (state_next == ST_GNT_A);
      gnt_b_reg <= (state_next == ST_GNT_B);
      if (grant_entry) begin
        last_owner_reg <= (state_next == ST_GNT_B) ? OWN_B : OWN_A;
        sel_reg        <= (state_next == ST_GNT_B) ? OWN_B : OWN_A;
      end
    end
  end

  assign gnt_a     = gnt_a_reg;
  assign gnt_b     = gnt_b_reg;
  assign sel       = sel_reg;
  assign valid_out = gnt_a_reg | gnt_b_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
    mux_2_1 u_mux (
      .A(data_a[gi]),
      .B(data_b[gi]),
      .S(sel_reg),
      .D(data_out[gi])
    );
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus random traffic
// compared against a behavioural owner/round-robin model.
module tb_mux2_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0;
  logic             req_b = 1'b0;
  logic [WIDTH-1:0] data_a = '0;
  logic [WIDTH-1:0] data_b = '0;
  logic             gnt_a, gnt_b, sel, valid_out;
  logic [WIDTH-1:0] data_out;

  mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .sel(sel), .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner 0 = nobody, 1 = A, 2 = B.
  int m_own  = 0;
  int m_last = 2;
  int m_hold = 0;
  bit m_sel  = 1'b0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update(bit ra, bit rb, bit rn);
    int nxt;
    if (!rn) begin
      m_own = 0; m_last = 2; m_sel = 1'b0; m_hold = 0;
      return;
    end
    nxt = m_own;
    if (m_own == 0) begin
      if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
    end else begin
      bit mine  = (m_own == 1) ? ra : rb;
      bit other = (m_own == 1) ? rb : ra;
      if (!mine) nxt = other ? 3 - m_own : 0;
`ifdef MUX2_ARBITER_TIMEOUT_EN
      else if (other && m_hold == MAX_HOLD - 1) nxt = 3 - m_own;
`endif
    end
    if (nxt != 0 && nxt != m_own) begin
      m_last = nxt; m_sel = (nxt == 2); m_hold = 0;
    end else if (nxt != 0 && m_hold < MAX_HOLD - 1) begin
      m_hold++;
    end
    m_own = nxt;
  endtask

  task automatic step(bit ra, bit rb, bit rn, logic [WIDTH-1:0] da, logic [WIDTH-1:0] db);
    logic [WIDTH-1:0] exp_data;
    req_a = ra; req_b = rb; rst_n = rn; data_a = da; data_b = db;
    @(posedge clk);
    model_update(ra, rb, rn);
    #1;
    exp_data = m_sel ? data_b : data_a;
    check_val("gnt_a",    32'(gnt_a),     32'(m_own == 1));
    check_val("gnt_b",    32'(gnt_b),     32'(m_own == 2));
    check_val("sel",      32'(sel),       32'(m_sel));
    check_val("valid",    32'(valid_out), 32'(m_own != 0));
    check_val("data_out", 32'(data_out),  32'(exp_data));
    check_val("onehot",   32'(gnt_a & gnt_b), 32'd0);
    $display("[TB] t=%0t rst_n=%0b req=%0b%0b gnt=%0b%0b sel=%0b dout=%0h",
             $time, rn, ra, rb, gnt_a, gnt_b, sel, data_out);
  endtask

  task automatic rstep(bit ra, bit rb, bit rn);
    step(ra, rb, rn, WIDTH'($urandom), WIDTH'($urandom));
  endtask

  initial begin
    int first_b;
    int a_cycles;

    // Reset then single request
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    check_val("rst_gnt_a", 32'(gnt_a), 32'd0);
    check_val("rst_sel",   32'(sel),   32'd0);
    check_val("rst_valid", 32'(valid_out), 32'd0);
    step(1, 0, 1, 8'h01, 8'hA5);
    check_val("single_gnt_a", 32'(gnt_a),    32'd1);
    check_val("single_data",  32'(data_out), 32'd1);
    check_val("single_gnt_b", 32'(gnt_b),    32'd0);

    // Tie after reset: A first, then direct handoff to B
    rstep(0, 0, 0);
    rstep(1, 1, 1);
    check_val("tie_first_a", 32'(gnt_a), 32'd1);
    rstep(0, 1, 1);
    check_val("handoff_b",   32'(gnt_b), 32'd1);
    check_val("handoff_sel", 32'(sel),   32'd1);

    // Round-robin alternation
    rstep(0, 0, 0);
    rstep(1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      rstep(0, 1, 1);
      check_val("rr_b", 32'(gnt_b), 32'd1);
      rstep(1, 1, 1);
      rstep(1, 0, 1);
      check_val("rr_a", 32'(gnt_a), 32'd1);
      rstep(1, 1, 1);
    end

    // Long hold with B waiting
    rstep(0, 0, 0);
    rstep(1, 0, 1);
    first_b  = -1;
    a_cycles = 1;
    rstep(1, 0, 1);
    if (gnt_a) a_cycles++;
    for (int k = 2; k < 22; k++) begin
      rstep(1, 1, 1);
      if (gnt_a) a_cycles++;
      if (gnt_b && first_b < 0) first_b = k;
    end
`ifdef MUX2_ARBITER_TIMEOUT_EN
    check_val("timeout_at", 32'(first_b), 32'd4);
`else
    check_val("no_timeout_hold", 32'(a_cycles), 32'd22);
`endif

    // Reset mid-grant
    rstep(0, 0, 0);
    rstep(0, 1, 1);
    rstep(0, 1, 1);
    rstep(0, 1, 0);
    check_val("midrst_gnt_b", 32'(gnt_b),     32'd0);
    check_val("midrst_sel",   32'(sel),       32'd0);
    check_val("midrst_valid", 32'(valid_out), 32'd0);
    rstep(0, 1, 1);
    check_val("midrst_regrant", 32'(gnt_b), 32'd1);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
